// File: rtl/bta_pkg.sv
// Shared helpers for the pipelined multi-operand ripple-carry tree adder.
package bta_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of the addends entering tree level j; the node output is one bit wider.
  function automatic int node_width(input int w, input int j);
    return w + j;
  endfunction

  function automatic int stage_count(input int n, input int lps);
    return (clog2(n) + lps - 1) / lps;
  endfunction

  localparam int N_DEF = 16;
  localparam int W_DEF = 16;
  localparam int S     = W_DEF + clog2(N_DEF);

endpackage

// File: rtl/bta_rca_node.sv
// One tree node: WIDTH-bit ripple-carry adder whose carry-out becomes the top sum bit.
module bta_rca_node #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    sum[WIDTH] = c;
  end

endmodule

// File: rtl/bta_rca_pipe.sv
// Pipelined N-operand binary tree adder with valid/ready flow control.
// Optional accumulator and sticky overflow enabled by macro BTA_RCA_ACC_EN.
module bta_rca_pipe
  import bta_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 16,
  parameter int LPS   = 1,
  parameter int ACC_W = W + clog2(N) + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_ops,
  input  logic             in_cin,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int LG = clog2(N);
  localparam int TS = node_width(W, LG);

  // Handshake: a beat transfers on a rising edge when valid & ready are both high.
  // The whole pipe moves in lock-step: it advances when the output slot is empty
  // or being drained, otherwise every bank holds (bubbles are kept, not squeezed).
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar j = 0; j < LG; j++) begin : gen_lvl
    localparam int NI = N >> j;
    localparam int NO = NI / 2;
    localparam int DW = node_width(W, j);

    logic [DW-1:0] din  [NI];
    logic          din_vld;
    logic          din_acc;
    logic [DW:0]   sum  [NO];
    logic [DW:0]   dout [NO];
    logic          dout_vld;
    logic          dout_acc;

    if (j == 0) begin : gen_src
      for (genvar k = 0; k < NI; k++) begin : gen_op
        assign din[k] = in_ops[k*W +: W];
      end
      assign din_vld = in_valid;
      assign din_acc = in_acc;
    end else begin : gen_src
      for (genvar k = 0; k < NI; k++) begin : gen_op
        assign din[k] = gen_lvl[j-1].dout[k];
      end
      assign din_vld = gen_lvl[j-1].dout_vld;
      assign din_acc = gen_lvl[j-1].dout_acc;
    end

    for (genvar i = 0; i < NO; i++) begin : gen_node
      logic node_cin;
      assign node_cin = (j == 0 && i == 0) ? in_cin : 1'b0;
      bta_rca_node #(.WIDTH(DW)) u_node (
        .a   (din[2*i]),
        .b   (din[2*i+1]),
        .cin (node_cin),
        .sum (sum[i])
      );
    end

    // The last level always feeds the output bank, so it is never registered here.
    if (j < LG - 1 && ((j + 1) % LPS) == 0) begin : gen_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_vld <= 1'b0;
          dout_acc <= 1'b0;
          for (int i = 0; i < NO; i++) dout[i] <= '0;
        end else if (adv) begin
          dout_vld <= din_vld;
          dout_acc <= din_acc;
          for (int i = 0; i < NO; i++) dout[i] <= sum[i];
        end
      end
    end else begin : gen_comb
      for (genvar i = 0; i < NO; i++) begin : gen_pass
        assign dout[i] = sum[i];
      end
      assign dout_vld = din_vld;
      assign dout_acc = din_acc;
    end
  end

  logic [TS-1:0]    tree_sum;
  logic             fin_vld;
  logic             fin_acc;
  logic [ACC_W-1:0] tree_ext;
  logic [ACC_W-1:0] sum_q;
  logic             vld_q;

  assign tree_sum  = gen_lvl[LG-1].dout[0];
  assign fin_vld   = gen_lvl[LG-1].dout_vld;
  assign fin_acc   = gen_lvl[LG-1].dout_acc;
  assign tree_ext  = ACC_W'(tree_sum);
  assign out_sum   = sum_q;
  assign out_valid = vld_q;

`ifdef BTA_RCA_ACC_EN
  logic [ACC_W:0] acc_add;
  logic           ovf_q;

  assign acc_add = {1'b0, sum_q} + {1'b0, tree_ext};
  assign out_ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q <= fin_vld;
      if (fin_vld) begin
        if (fin_acc) begin
          sum_q <= acc_add[ACC_W-1:0];
          ovf_q <= ovf_q | acc_add[ACC_W];
        end else begin
          sum_q <= tree_ext;
          ovf_q <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_acc;
  assign unused_acc = fin_acc;
  assign out_ovf    = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sum_q <= '0;
    end else if (adv) begin
      vld_q <= fin_vld;
      if (fin_vld) sum_q <= tree_ext;
    end
  end
`endif

endmodule

// File: tb/tb_bta_rca_pipe.sv
// Directed-vector bench for bta_rca_pipe with an expected-value queue and a decoupled output monitor.
module tb_bta_rca_pipe;

  localparam int N   = 16;
  localparam int W   = 16;
  localparam int LPS = 1;
`ifdef BTA_RCA_ACC_EN
  localparam int ACC_W = 20;
`else
  localparam int ACC_W = 28;
`endif
  localparam int LAT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_ops;
  logic             in_cin;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  bta_rca_pipe #(.N(N), .W(W), .LPS(LPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_cin    (in_cin),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  // clock / reset-cycle bookkeeping
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [ACC_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];
  int               acc_cyc_q[$];
  int               checks = 0;
  int               errors = 0;
  int               n_rx = 0;
  bit               lat_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] ramp();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(k + 1);
    return r;
  endfunction

  // driver: present a beat, push its expectation in the cycle it is accepted
  task automatic send(input logic [N*W-1:0] ops, input logic cin, input logic acc,
                      input logic [ACC_W-1:0] es, input logic eo);
    int n;
    n        = 0;
    in_ops   = ops;
    in_cin   = cin;
    in_acc   = acc;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(es);
        exp_ovf_q.push_back(eo);
        acc_cyc_q.push_back(cyc);
        break;
      end
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 64'(in_ready), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every transferred result against the queue head
  logic             prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_sum;
  initial begin
    logic [ACC_W-1:0] es;
    logic             eo;
    int               ac;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          chk("in_ready_stall", 64'(in_ready), 64'(0));
          if (prev_stall) chk("hold_sum", 64'(out_sum), 64'(prev_sum));
          prev_stall = 1'b1;
          prev_sum   = out_sum;
        end else begin
          prev_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected none (cycle %0d)", out_sum, cyc);
          end else begin
            es = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
            ac = acc_cyc_q.pop_front();
            chk("out_sum", 64'(out_sum), 64'(es));
            chk("out_ovf", 64'(out_ovf), 64'(eo));
            if (lat_chk) chk("latency", 64'(cyc - ac), 64'(LAT));
            n_rx++;
          end
        end
      end
    end
  end

  initial begin
    int rx0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ops    = '0;
    in_cin    = 1'b0;
    in_acc    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // full-range single beat with carry-in, latency checked
    lat_chk = 1'b1;
    send(fill(16'hFFFF), 1'b1, 1'b0, ACC_W'(20'hFFFF1), 1'b0);
    drain();

    // back-to-back ramp beats: one result per cycle at fixed latency
    for (int b = 0; b < 8; b++) send(ramp(), 1'b0, 1'b0, ACC_W'(136), 1'b0);
    drain();
    lat_chk = 1'b0;

    // streaming with a 6-cycle output stall
    rx0 = n_rx;
    fork
      begin
        for (int b = 0; b < 12; b++)
          send(fill(W'(b + 1)), 1'b0, 1'b0, ACC_W'(16 * (b + 1)), 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_rx_count", 64'(n_rx - rx0), 64'(12));

`ifdef BTA_RCA_ACC_EN
    send(fill(16'h0001), 1'b0, 1'b0, ACC_W'(16), 1'b0);
    send(fill(16'h0001), 1'b0, 1'b1, ACC_W'(32), 1'b0);
    send(fill(16'h0001), 1'b0, 1'b1, ACC_W'(48), 1'b0);
    drain();

    send(fill(16'hFFFF), 1'b0, 1'b0, ACC_W'(20'hFFFF0), 1'b0);
    send(fill(16'hFFFF), 1'b0, 1'b1, ACC_W'(20'hFFFE0), 1'b1);
    send(fill(16'h0001), 1'b0, 1'b0, ACC_W'(16), 1'b0);
    drain();
`endif

    // reset with three beats in flight
    for (int b = 0; b < 3; b++) send(fill(16'h0005), 1'b0, 1'b0, ACC_W'(80), 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf_q.delete();
    acc_cyc_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_sum", 64'(out_sum), 64'(0));
    chk("midrst_out_ovf", 64'(out_ovf), 64'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    send(fill(16'h0001), 1'b0, 1'b1, ACC_W'(16), 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
